modn_fsm: RTL and testbench

Parametrised modulo-N state counter, the general successor to the two-state toggle FSM. It steps through states 0..N-1 under an enable, counts up or down, and accepts a synchronous parallel load. It flags state 0 on `Y` and gives a one-cycle registered terminal-count pulse on every wrap. Divider, sequencing and round-robin logic on the DE1 use it wherever a fixed-length cyclic state sequence is needed.

---
 rtl/modn_fsm.sv | 81 ++++++++
 tb/tb_modn_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/modn_fsm.sv
// Modulo-N up/down state counter with synchronous load, zero decode and wrap pulse.
// Define MODN_FSM_SATURATE_EN to saturate at 0 / N-1 instead of wrapping.
module modn_fsm #(
    parameter int unsigned N = 5,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         CLK,
    input  logic         R,
    input  logic         A,
    input  logic         DIR,
    input  logic         LD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         Y,
    output logic         TC
);

    localparam int unsigned WE = W + 1;

    localparam logic [W-1:0]  STATE_FIRST = '0;
    localparam logic [W-1:0]  STATE_LAST  = W'(N - 1);
    localparam logic [WE-1:0] LAST_EXT    = WE'(N - 1);
    localparam logic [WE-1:0] MOD_EXT     = WE'(N);

    logic [W-1:0]  qNext;
    logic          tcNext;
    logic [WE-1:0] qExt;
    logic [WE-1:0] dExt;

    assign qExt = {1'b0, Q};
    assign dExt = {1'b0, D};

    // State register
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            Q  <= STATE_FIRST;
            TC <= 1'b0;
        end else begin
            Q  <= qNext;
            TC <= tcNext;
        end
    end

    // Next state: load beats step beats hold; out-of-range states recover to 0
    always_comb begin
        qNext  = Q;
        tcNext = 1'b0;
        if (LD) begin
            qNext = (dExt < MOD_EXT) ? D : STATE_LAST;
        end else if (A) begin
            if (qExt > LAST_EXT) begin
                qNext = STATE_FIRST;
            end else if (!DIR) begin
                if (qExt == LAST_EXT) begin
`ifdef MODN_FSM_SATURATE_EN
                    qNext  = STATE_LAST;
`else
                    qNext  = STATE_FIRST;
`endif
                    tcNext = 1'b1;
                end else begin
                    qNext = W'(qExt + WE'(1));
                end
            end else begin
                if (Q == STATE_FIRST) begin
`ifdef MODN_FSM_SATURATE_EN
                    qNext  = STATE_FIRST;
`else
                    qNext  = STATE_LAST;
`endif
                    tcNext = 1'b1;
                end else begin
                    qNext = W'(qExt - WE'(1));
                end
            end
        end
    end

    assign Y = (Q == STATE_FIRST);

endmodule

// File: tb/tb_modn_fsm.sv
// Scoreboard bench for modn_fsm at N=5, N=2 and N=1; expectations follow MODN_FSM_SATURATE_EN.
module tb_modn_fsm;

    logic       CLK = 1'b0;
    logic       R;
    logic       A;
    logic       DIR;
    logic       LD;
    logic [2:0] D5;
    logic       D2;
    logic       D1;
    logic [2:0] Q5;
    logic       Y5, TC5;
    logic       Q2, Y2, TC2;
    logic       Q1, Y1, TC1;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic       ld;
        logic       a;
        logic       dir;
        logic [2:0] d;
        logic [2:0] q;
        logic       tc;
    } step_t;

    step_t sb[$];

    modn_fsm #(.N(5)) dut5 (.CLK(CLK), .R(R), .A(A), .DIR(DIR), .LD(LD), .D(D5), .Q(Q5), .Y(Y5), .TC(TC5));
    modn_fsm #(.N(2)) dut2 (.CLK(CLK), .R(R), .A(A), .DIR(DIR), .LD(LD), .D(D2), .Q(Q2), .Y(Y2), .TC(TC2));
    modn_fsm #(.N(1)) dut1 (.CLK(CLK), .R(R), .A(A), .DIR(DIR), .LD(LD), .D(D1), .Q(Q1), .Y(Y1), .TC(TC1));

    always #5 CLK = ~CLK;

    task automatic push(input logic ld, input logic a, input logic dir,
                        input logic [2:0] d, input logic [2:0] q, input logic tc);
        step_t s;
        s.ld = ld; s.a = a; s.dir = dir; s.d = d; s.q = q; s.tc = tc;
        sb.push_back(s);
    endtask

    task automatic test_reset();
        R = 1'b1; A = 1'b0; DIR = 1'b0; LD = 1'b0; D5 = 3'd0; D2 = 1'b0; D1 = 1'b0;
        #2;
        nChecks++;
        if ({Q5, Y5, TC5} !== {3'd0, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL reset n5: got Q=%0d Y=%b TC=%b, want Q=0 Y=1 TC=0", Q5, Y5, TC5);
        end
        nChecks++;
        if ({Q2, Y2, TC2} !== {1'b0, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL reset n2: got Q=%0d Y=%b TC=%b, want Q=0 Y=1 TC=0", Q2, Y2, TC2);
        end
        nChecks++;
        if ({Q1, Y1, TC1} !== {1'b0, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL reset n1: got Q=%0d Y=%b TC=%b, want Q=0 Y=1 TC=0", Q1, Y1, TC1);
        end
        @(negedge CLK);
        R = 1'b0;
    endtask

    task automatic test_count_up();
        step_t s;
        int    k = 0;
`ifdef MODN_FSM_SATURATE_EN
        push(0, 1, 0, 0, 3'd1, 0); push(0, 1, 0, 0, 3'd2, 0); push(0, 1, 0, 0, 3'd3, 0);
        push(0, 1, 0, 0, 3'd4, 0); push(0, 1, 0, 0, 3'd4, 1); push(0, 1, 0, 0, 3'd4, 1);
        push(0, 1, 1, 0, 3'd3, 0); push(0, 1, 1, 0, 3'd2, 0); push(0, 1, 1, 0, 3'd1, 0);
        push(0, 1, 1, 0, 3'd0, 0); push(0, 1, 1, 0, 3'd0, 1);
`else
        for (int i = 1; i <= 10; i++)
            push(0, 1, 0, 0, 3'(i % 5), (i % 5) == 0);
`endif
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge CLK);
            LD = s.ld; A = s.a; DIR = s.dir; D5 = s.d;
            @(posedge CLK); #1;
            nChecks++;
            if ({Q5, Y5, TC5} !== {s.q, s.q == 3'd0, s.tc}) begin
                nFail++;
                $display("FAIL count step %0d: got Q=%0d Y=%b TC=%b, want Q=%0d Y=%b TC=%b",
                         k, Q5, Y5, TC5, s.q, s.q == 3'd0, s.tc);
            end
            k++;
        end
    endtask

    task automatic test_count_down();
        step_t s;
        int    k = 0;
`ifdef MODN_FSM_SATURATE_EN
        push(0, 1, 1, 0, 3'd0, 1); push(0, 1, 1, 0, 3'd0, 1); push(0, 1, 1, 0, 3'd0, 1);
`else
        push(0, 1, 1, 0, 3'd4, 1); push(0, 1, 1, 0, 3'd3, 0); push(0, 1, 1, 0, 3'd2, 0);
`endif
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge CLK);
            LD = s.ld; A = s.a; DIR = s.dir; D5 = s.d;
            @(posedge CLK); #1;
            nChecks++;
            if ({Q5, Y5, TC5} !== {s.q, s.q == 3'd0, s.tc}) begin
                nFail++;
                $display("FAIL down step %0d: got Q=%0d Y=%b TC=%b, want Q=%0d Y=%b TC=%b",
                         k, Q5, Y5, TC5, s.q, s.q == 3'd0, s.tc);
            end
            k++;
        end
    endtask

    task automatic test_load();
        step_t s;
        int    k = 0;
        push(1, 1, 0, 3'd3, 3'd3, 0);
        push(1, 1, 0, 3'd7, 3'd4, 0);
        push(1, 1, 0, 3'd4, 3'd4, 0);
`ifdef MODN_FSM_SATURATE_EN
        push(0, 1, 0, 3'd0, 3'd4, 1);
`else
        push(0, 1, 0, 3'd0, 3'd0, 1);
`endif
        push(1, 1, 1, 3'd0, 3'd0, 0);
        push(1, 1, 0, 3'd5, 3'd4, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge CLK);
            LD = s.ld; A = s.a; DIR = s.dir; D5 = s.d;
            @(posedge CLK); #1;
            nChecks++;
            if ({Q5, Y5, TC5} !== {s.q, s.q == 3'd0, s.tc}) begin
                nFail++;
                $display("FAIL load step %0d: got Q=%0d Y=%b TC=%b, want Q=%0d Y=%b TC=%b",
                         k, Q5, Y5, TC5, s.q, s.q == 3'd0, s.tc);
            end
            k++;
        end
    endtask

    task automatic test_async_reset();
        step_t s;
        push(1, 0, 0, 3'd3, 3'd3, 0);
        push(0, 1, 0, 3'd0, 3'd4, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge CLK);
            LD = s.ld; A = s.a; DIR = s.dir; D5 = s.d;
            @(posedge CLK); #1;
            nChecks++;
            if ({Q5, TC5} !== {s.q, s.tc}) begin
                nFail++;
                $display("FAIL pre-reset: got Q=%0d TC=%b, want Q=%0d TC=%b", Q5, TC5, s.q, s.tc);
            end
        end
        nChecks++;
        if (TC1 !== 1'b1) begin
            nFail++;
            $display("FAIL n1 tc before reset: got %b, want 1", TC1);
        end
        #2 R = 1'b1;
        #1;
        nChecks++;
        if ({Q5, Y5, TC5} !== {3'd0, 1'b1, 1'b0}) begin
            nFail++;
            $display("FAIL async reset n5: got Q=%0d Y=%b TC=%b, want Q=0 Y=1 TC=0", Q5, Y5, TC5);
        end
        nChecks++;
        if (TC1 !== 1'b0) begin
            nFail++;
            $display("FAIL async reset n1 tc cancel: got %b, want 0", TC1);
        end
        @(negedge CLK);
        R = 1'b0;
        @(posedge CLK); #1;
        nChecks++;
        if ({Q5, Y5, TC5} !== {3'd1, 1'b0, 1'b0}) begin
            nFail++;
            $display("FAIL resume after reset: got Q=%0d Y=%b TC=%b, want Q=1 Y=0 TC=0", Q5, Y5, TC5);
        end
        @(negedge CLK);
        A = 1'b0;
    endtask

    task automatic test_n2_n1();
        logic eq2;
        logic etc2;
        @(negedge CLK);
        R = 1'b1; A = 1'b0; LD = 1'b0; DIR = 1'b0;
        #1;
        nChecks++;
        if (Y2 !== 1'b1) begin
            nFail++;
            $display("FAIL n2 initial Y: got %b, want 1", Y2);
        end
        @(negedge CLK);
        R = 1'b0; A = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
`ifdef MODN_FSM_SATURATE_EN
            eq2  = 1'b1;
            etc2 = (i > 0);
`else
            eq2  = (i % 2 == 0);
            etc2 = !eq2;
`endif
            nChecks++;
            if ({Q2, Y2, TC2} !== {eq2, !eq2, etc2}) begin
                nFail++;
                $display("FAIL n2 cycle %0d: got Q=%0d Y=%b TC=%b, want Q=%0d Y=%b TC=%b",
                         i, Q2, Y2, TC2, eq2, !eq2, etc2);
            end
            nChecks++;
            if ({Q1, Y1, TC1} !== {1'b0, 1'b1, 1'b1}) begin
                nFail++;
                $display("FAIL n1 cycle %0d: got Q=%0d Y=%b TC=%b, want Q=0 Y=1 TC=1", i, Q1, Y1, TC1);
            end
        end
        @(negedge CLK);
        A = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_async_reset();
        test_n2_n1();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
